// File: rtl/div_pkg.sv
// Shared definitions for the signed 2W/W divider: FSM encoding, default width
// and the saturation patterns used for overflow and divide-by-zero results.
package div_pkg;

   localparam int DIV_WIDTH = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Largest positive / most negative w-bit two's complement values, zero-extended.
   function automatic logic [63:0] sat_pos(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_neg(input int w);
      return 64'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial-subtract the divisor magnitude from the
// shifted partial remainder and keep the difference only when it does not go negative.
module div_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH:0]   partial,
   input  logic [WIDTH-1:0] dvs_mag,
   output logic [WIDTH-1:0] rem_next,
   output logic             qbit
);

   always_comb begin
      qbit     = (partial >= {1'b0, dvs_mag});
      // When qbit is set the difference is below dvs_mag, so it fits WIDTH bits.
      rem_next = qbit ? WIDTH'(partial - {1'b0, dvs_mag}) : partial[WIDTH-1:0];
   end

endmodule

// File: rtl/div_top.sv
// Truncating signed divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient
// bit per cycle on magnitudes, signs applied and overflow saturated at the end.
module div_top
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               ovf,
   output logic               dz,
   output logic [1:0]         fsm_state
);

   localparam int                   CNT_W = $clog2(2 * WIDTH + 1);
   localparam logic [CNT_W-1:0]     ITERS = CNT_W'(2 * WIDTH);
   localparam logic [WIDTH-1:0]     Q_POS = WIDTH'(sat_pos(WIDTH));
   localparam logic [WIDTH-1:0]     Q_NEG = WIDTH'(sat_neg(WIDTH));
   localparam logic [2*WIDTH-1:0]   LIM_POS = (2 * WIDTH)'(sat_pos(WIDTH));
   localparam logic [2*WIDTH-1:0]   LIM_NEG = (2 * WIDTH)'(sat_neg(WIDTH));

   state_t               state, state_nxt;
   logic [2*WIDTH-1:0]   acc;        // dividend magnitude shifting out, quotient shifting in
   logic [WIDTH-1:0]     rem;
   logic [WIDTH-1:0]     dvs;
   logic                 sgn_d, sgn_v;
   logic [CNT_W-1:0]     cnt;

   logic [2*WIDTH-1:0]   dvd_mag;
   logic [WIDTH-1:0]     dvs_mag;
   logic [WIDTH-1:0]     rem_next;
   logic                 qbit;
   logic                 neg, ovf_c;
   logic [WIDTH-1:0]     q_signed, r_signed;

   div_step #(.WIDTH(WIDTH)) u_step (
      .partial  ({rem, acc[2*WIDTH-1]}),
      .dvs_mag  (dvs),
      .rem_next (rem_next),
      .qbit     (qbit)
   );

   always_comb begin
      dvd_mag  = dividend[2*WIDTH-1] ? -dividend : dividend;
      dvs_mag  = divisor[WIDTH-1] ? -divisor : divisor;
      neg      = sgn_d ^ sgn_v;
      ovf_c    = neg ? (acc > LIM_NEG) : (acc > LIM_POS);
      q_signed = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      r_signed = sgn_d ? -rem : rem;
   end

   // Handshake: operands transfer on a rising edge with in_valid && in_ready; a result
   // transfers with out_valid && out_ready. The two never coincide, so a new operand is
   // accepted at the earliest one cycle after a result is consumed.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = (divisor == '0) ? S_DONE : S_CALC;
         end
         S_CALC: if (cnt == ITERS) state_nxt = S_FIX;
         S_FIX:  state_nxt = S_DONE;
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         quotient  <= '0;
         remainder <= '0;
         ovf       <= 1'b0;
         dz        <= 1'b0;
         cnt       <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: if (in_valid) begin
               acc   <= dvd_mag;
               dvs   <= dvs_mag;
               rem   <= '0;
               cnt   <= '0;
               sgn_d <= dividend[2*WIDTH-1];
               sgn_v <= divisor[WIDTH-1];
               if (divisor == '0) begin
                  quotient  <= dividend[2*WIDTH-1] ? Q_NEG : Q_POS;
                  remainder <= dividend[WIDTH-1:0];
                  ovf       <= 1'b0;
                  dz        <= 1'b1;
               end
            end
            S_CALC: if (cnt != ITERS) begin
               acc <= {acc[2*WIDTH-2:0], qbit};
               rem <= rem_next;
               cnt <= cnt + 1'b1;
            end
            S_FIX: begin
               quotient  <= ovf_c ? (neg ? Q_NEG : Q_POS) : q_signed;
               remainder <= r_signed;
               ovf       <= ovf_c;
               dz        <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_div_top.sv
// Bench for div_top: directed corner cases with literal expectations, reset
// behaviour, multiplier round trips and random operands against an arithmetic model.
module tb_div_top;

   localparam int W        = 16;
   localparam int N_RT     = 1000;
   localparam int N_ARB    = 500;
   localparam int LAT_CALC = 2 * W + 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           out_ready = 1'b0;
   logic [2*W-1:0] dividend = '0;
   logic [W-1:0]   divisor = '0;
   logic           in_ready, out_valid, ovf, dz;
   logic [W-1:0]   quotient, remainder;
   logic [1:0]     fsm_state;

   int             n_cmp = 0;
   int             n_bad = 0;
   logic [33:0]    exp_q[$];   // {ovf, dz, quotient, remainder}

   div_top #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .ovf       (ovf),
      .dz        (dz),
      .fsm_state (fsm_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, want);
      end
   endtask

   // Reference: plain truncating division on wide integers, then range/saturation rules.
   function automatic logic [33:0] ref_div(input logic signed [31:0] n, input logic signed [15:0] d);
      longint ln;
      longint ld;
      longint q;
      longint r;
      ln = n;
      ld = d;
      if (ld == 0) return {1'b0, 1'b1, (ln < 0) ? 16'h8000 : 16'h7FFF, n[15:0]};
      q = ln / ld;
      r = ln % ld;
      if (q > 32767)  return {1'b1, 1'b0, 16'h7FFF, r[15:0]};
      if (q < -32768) return {1'b1, 1'b0, 16'h8000, r[15:0]};
      return {1'b0, 1'b0, q[15:0], r[15:0]};
   endfunction

   // ---------------- driver ----------------
   task automatic run_op(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                         input logic [33:0] want, input int hold);
      int          waited;
      int          lat;
      logic [33:0] got;
      logic [33:0] e;
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "_in_ready"}, in_ready, 1);
      exp_q.push_back(want);
      in_valid = 1'b1;
      dividend = dvd;
      divisor  = dvs;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (lat < 200) begin
         dividend = $urandom;
         divisor  = 16'($urandom);
         @(posedge clk);
         #1;
         lat++;
         if (out_valid) break;
      end
      check({tag, "_latency"}, lat, (dvs == 16'h0) ? 1 : LAT_CALC);
      @(negedge clk);
      got = {ovf, dz, quotient, remainder};
      e = exp_q.pop_front();
      check({tag, "_result"}, got, e);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold"}, {out_valid, in_ready, ovf, dz, quotient, remainder},
               {2'b10, e});
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_consume"}, {out_valid, in_ready}, 2'b01);
   endtask

   task automatic round_trip(input logic signed [15:0] a, input logic signed [15:0] b);
      logic signed [31:0] p;
      p = a * b;
      run_op("round_trip", p, b, {2'b00, a, 16'h0000}, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic signed [15:0] a;
      logic signed [15:0] b;
      logic [31:0]        dvd;
      logic [15:0]        dvs;
      logic               seen;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("reset_ready_valid", {in_ready, out_valid}, 2'b10);
      check("reset_outputs", {ovf, dz, quotient, remainder}, 34'h0);
      check("reset_state", fsm_state, 2'd0);

      run_op("div_100_7", 32'd100, 16'd7, {2'b00, 16'd14, 16'd2}, 10);
      run_op("div_m100_7", 32'hFFFF_FF9C, 16'd7, {2'b00, 16'hFFF2, 16'hFFFE}, 0);
      run_op("div_2p30_m2p15", 32'h4000_0000, 16'h8000, {2'b00, 16'h8000, 16'h0000}, 0);
      run_op("ovf_min_m1", 32'h8000_0000, 16'hFFFF, {2'b10, 16'h7FFF, 16'h0000}, 0);
      run_op("ovf_2p30_2", 32'h4000_0000, 16'd2, {2'b10, 16'h7FFF, 16'h0000}, 0);
      run_op("ovf_neg_sat", 32'hC000_0000, 16'd3, {2'b10, 16'h8000, 16'hFFFF}, 0);
      run_op("dz_m5", 32'hFFFF_FFFB, 16'h0000, {2'b01, 16'h8000, 16'hFFFB}, 3);
      run_op("dz_pos", 32'h0001_2345, 16'h0000, {2'b01, 16'h7FFF, 16'h2345}, 0);

      // Abandon an operation mid-iteration; no result may appear afterwards.
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 32'd1000;
      divisor  = 16'd3;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midcalc_reset_ready_valid", {in_ready, out_valid}, 2'b10);
      check("midcalc_reset_outputs", {ovf, dz, quotient, remainder}, 34'h0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("midcalc_no_result", seen, 1'b0);

      round_trip(16'sh7FFF, 16'sh7FFF);
      round_trip(-16'sd1, -16'sd1);
      round_trip(16'sh8000, 16'sh8000);
      round_trip(16'sh8000, 16'sd1);
      round_trip(16'sd0, 16'sd5);

      for (int i = 0; i < N_RT; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         while (b == 0) b = 16'($urandom);
         round_trip(a, b);
      end

      for (int i = 0; i < N_ARB; i++) begin
         if ($urandom_range(0, 3) == 0) dvd = $urandom;
         else dvd = {{16{1'b0}}, 16'($urandom)} ^ {32{$urandom_range(0, 1) == 1}};
         if ($urandom_range(0, 9) == 0) dvs = 16'h0000;
         else if ($urandom_range(0, 1) == 0) dvs = 16'($urandom_range(1, 40));
         else dvs = 16'($urandom);
         run_op("random", dvd, dvs, ref_div(dvd, dvs), $urandom_range(0, 2));
      end

      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
